// File: rtl/lotr_mem_loader.sv
// Byte-stream program loader: unpacks HDR/LEN/DATA frames into word writes for tile I_MEM/D_MEM.
// Define LOTR_LOADER_CHECKSUM_EN to expect an XOR checksum word after the END marker.
module lotr_mem_loader #(
  parameter int          NUM_TILE     = 2,
  parameter logic [31:0] I_MEM_OFFSET = 32'h0000,
  parameter logic [31:0] SIZE_I_MEM   = 32'h1000,
  parameter logic [31:0] D_MEM_OFFSET = 32'h1000,
  parameter logic [31:0] SIZE_D_MEM   = 32'h1000
) (
  input  logic                QClk,
  input  logic                RstQnnnH,
  input  logic                LdValidQnnnH,
  input  logic [7:0]          LdByteQnnnH,
  output logic                LdRdyQnnnH,
  output logic                MemWrEnQnnnH,
  output logic [NUM_TILE-1:0] MemWrTileQnnnH,
  output logic                MemWrSelQnnnH,
  output logic [23:0]         MemWrAddrQnnnH,
  output logic [31:0]         MemWrDataQnnnH,
  input  logic                MemWrRdyQnnnH,
  output logic                CoreRstQnnnH,
  output logic                LdDoneQnnnH,
  output logic                LdErrQnnnH
);

  // state | meaning
  // IDLE  | first cycle out of reset, loader not yet ready
  // HDR   | collecting header word (or END marker)
  // LEN   | collecting length word, frame checked on its last byte
  // DATA  | collecting a data word (discarded if the frame is bad)
  // WR    | write request held until the memory side accepts
  // CKSUM | collecting the checksum word after END
  // DONE  | load finished, terminal until reset
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_DATA, S_WR, S_CKSUM, S_DONE} state_t;

`ifdef LOTR_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CKSUM;
`else
  localparam state_t END_STATE = S_DONE;
`endif
  localparam logic [7:0]          TILE_LIM = 8'(NUM_TILE);
  localparam logic [NUM_TILE-1:0] TILE_ONE = NUM_TILE'(1);

  state_t               state, state_nxt;
  logic [1:0]           bcnt;
  logic [23:0]          sh;
  logic [31:0]          word;
  logic                 xfer, word_done;
  logic [6:0]           tile_id;
  logic [15:0]          cnt;
  logic                 discard;
  logic [NUM_TILE-1:0]  wr_tile, tile_mask;
  logic                 wr_sel;
  logic [23:0]          wr_addr;
  logic [31:0]          wr_data;
  logic                 err, done, core_rst;
  logic                 frame_bad, ck_bad;
  logic [31:0]          lo, hi, last;
`ifdef LOTR_LOADER_CHECKSUM_EN
  logic [31:0]          csum;
`endif

  assign xfer      = LdValidQnnnH & LdRdyQnnnH;
  assign word      = {LdByteQnnnH, sh};
  assign word_done = xfer && (bcnt == 2'd3);
  assign tile_mask = (tile_id == 7'h7F) ? '1 : (TILE_ONE << tile_id);

  // Range check uses the header latched in wr_sel/wr_addr/tile_id and the incoming LEN word.
  always_comb begin
    lo        = wr_sel ? D_MEM_OFFSET : I_MEM_OFFSET;
    hi        = wr_sel ? (D_MEM_OFFSET + SIZE_D_MEM) : (I_MEM_OFFSET + SIZE_I_MEM);
    last      = {8'h00, wr_addr} + {14'h0, word[15:0], 2'b00};
    frame_bad = (wr_addr[1:0] != 2'b00)
             || ((tile_id != 7'h7F) && ({1'b0, tile_id} >= TILE_LIM))
             || ({8'h00, wr_addr} < lo)
             || (last > hi);
  end

`ifdef LOTR_LOADER_CHECKSUM_EN
  assign ck_bad = (state == S_CKSUM) && (word != csum);
`else
  assign ck_bad = 1'b0;
`endif

  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_HDR;
      S_HDR:   if (word_done) state_nxt = (word == '1) ? END_STATE : S_LEN;
      S_LEN:   if (word_done) state_nxt = (word[15:0] == 16'h0) ? S_HDR : S_DATA;
      S_DATA:  if (word_done) begin
                 if (!discard)         state_nxt = S_WR;
                 else if (cnt == 16'd1) state_nxt = S_HDR;
               end
      S_WR:    if (MemWrRdyQnnnH) state_nxt = (cnt == 16'd1) ? S_HDR : S_DATA;
      S_CKSUM: if (word_done) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    LdRdyQnnnH   = (state == S_HDR) || (state == S_LEN) || (state == S_DATA) || (state == S_CKSUM);
    MemWrEnQnnnH = (state == S_WR);
  end

  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      bcnt     <= 2'd0;
      sh       <= 24'h0;
      tile_id  <= 7'h0;
      cnt      <= 16'h0;
      discard  <= 1'b0;
      wr_tile  <= '0;
      wr_sel   <= 1'b0;
      wr_addr  <= 24'h0;
      wr_data  <= 32'h0;
      err      <= 1'b0;
      done     <= 1'b0;
      core_rst <= 1'b1;
`ifdef LOTR_LOADER_CHECKSUM_EN
      csum     <= 32'h0;
`endif
    end else begin
      if (xfer) begin
        bcnt <= bcnt + 2'd1;
        sh   <= {LdByteQnnnH, sh[23:8]};
      end
      case (state)
        S_HDR: if (word_done && (word != '1)) begin
          wr_sel  <= word[31];
          tile_id <= word[30:24];
          wr_addr <= word[23:0];
        end
        S_LEN: if (word_done) begin
          cnt     <= word[15:0];
          discard <= frame_bad;
          wr_tile <= tile_mask;
          if (frame_bad) err <= 1'b1;
        end
        S_DATA: if (word_done) begin
          if (discard) cnt <= cnt - 16'd1;
          else         wr_data <= word;
        end
        S_WR: if (MemWrRdyQnnnH) begin
          cnt     <= cnt - 16'd1;
          wr_addr <= wr_addr + 24'd4;
`ifdef LOTR_LOADER_CHECKSUM_EN
          csum    <= csum ^ wr_data;
`endif
        end
        S_CKSUM: if (word_done && ck_bad) err <= 1'b1;
        default: ;
      endcase
      // Cores are released only when the whole image, checksum included, is clean.
      if ((state != S_DONE) && (state_nxt == S_DONE)) begin
        done     <= !err && !ck_bad;
        core_rst <= err || ck_bad;
      end
    end
  end

  assign MemWrTileQnnnH = wr_tile;
  assign MemWrSelQnnnH  = wr_sel;
  assign MemWrAddrQnnnH = wr_addr;
  assign MemWrDataQnnnH = wr_data;
  assign CoreRstQnnnH   = core_rst;
  assign LdDoneQnnnH    = done;
  assign LdErrQnnnH     = err;

endmodule

// File: tb/tb_lotr_mem_loader.sv
// Randomized bench for lotr_mem_loader: frame-level reference model plus per-cycle write checker.
module tb_lotr_mem_loader;
  localparam int NT = 2;

  logic        clk = 1'b0, rst = 1'b0, vld = 1'b0, rdy = 1'b0;
  logic [7:0]  bt = 8'h0;
  logic        ldrdy, en, sel, core_rst, done, err;
  logic [1:0]  tile;
  logic [23:0] addr;
  logic [31:0] data;

  lotr_mem_loader #(.NUM_TILE(NT)) dut (
    .QClk(clk), .RstQnnnH(rst), .LdValidQnnnH(vld), .LdByteQnnnH(bt),
    .LdRdyQnnnH(ldrdy), .MemWrEnQnnnH(en), .MemWrTileQnnnH(tile),
    .MemWrSelQnnnH(sel), .MemWrAddrQnnnH(addr), .MemWrDataQnnnH(data),
    .MemWrRdyQnnnH(rdy), .CoreRstQnnnH(core_rst), .LdDoneQnnnH(done),
    .LdErrQnnnH(err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  tile;
    logic        sel;
    logic [23:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         log_q[$];
  int          n_vec = 0, n_err = 0;
  bit          exp_err = 0;
  logic [31:0] exp_csum = 0;
  int          rdy_mode = 0;  // 0 random, 1 held low, 2 held high
  bit          gaps = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       rdy = 1'b0;
      2:       rdy = 1'b1;
      default: rdy = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Write checker: every accepted request must match the model's next expected write,
  // and a stalled request must not change.
  wr_t prev;
  bit  pend = 0;
  always @(negedge clk) begin
    wr_t cur, e;
    cur = {tile, sel, addr, data};
    if (rst) pend = 0;
    else begin
      if (en) begin
        chk("ldrdy_low_in_wr", ldrdy, 0);
        if (pend) chk("wr_hold", cur, prev);
      end
      if (en && rdy) begin
        if (exp_q.size() == 0) chk("write_expected", exp_q.size() != 0, 1);
        else begin
          e = exp_q.pop_front();
          chk("wr_tile", tile, e.tile);
          chk("wr_sel", sel, e.sel);
          chk("wr_addr", addr, e.addr);
          chk("wr_data", data, e.data);
        end
        log_q.push_back(cur);
      end
      pend = en && !rdy;
      prev = cur;
    end
  end

  function automatic bit frame_bad(input logic [31:0] hdr, input logic [15:0] len);
    longint a, base, t;
    a    = longint'(hdr[23:0]);
    t    = longint'(hdr[30:24]);
    base = hdr[31] ? 'h1000 : 'h0;
    return (a % 4 != 0) || (t != 127 && t >= NT) || (a < base) ||
           (a + 4 * longint'(len) > base + 'h1000);
  endfunction

  task automatic model_frame(input logic [31:0] hdr, input logic [15:0] len, input logic [31:0] d[$]);
    wr_t w;
    int  t;
    if (frame_bad(hdr, len)) exp_err = 1;
    else begin
      t = int'(hdr[30:24]);
      for (int i = 0; i < int'(len); i++) begin
        w.tile = (t == 127) ? 2'b11 : 2'(1 << t);
        w.sel  = hdr[31];
        w.addr = hdr[23:0] + 24'(4 * i);
        w.data = d[i];
        exp_q.push_back(w);
        exp_csum ^= d[i];
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    if (gaps && $urandom_range(0, 3) == 0) begin
      vld = 0;
      @(negedge clk);
    end
    vld = 1; bt = b; t = 0;
    while (!ldrdy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("ldrdy_timeout", t < 3000, 1);
    @(negedge clk);
    vld = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] lw, input logic [31:0] d[$],
                            input bit use_model);
    if (use_model) model_frame(hdr, lw[15:0], d);
    send_word(hdr);
    send_word(lw);
    foreach (d[i]) send_word(d[i]);
  endtask

  task automatic do_reset();
    #2 rst = 1;
    #1;
    chk("rst_ldrdy", ldrdy, 0);
    chk("rst_wren", en, 0);
    chk("rst_tile", tile, 0);
    chk("rst_sel", sel, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 0;
    exp_q.delete(); log_q.delete();
    exp_err = 0; exp_csum = 0; rdy_mode = 0;
    #1 chk("ldrdy_in_reset_exit", ldrdy, 0);
    @(negedge clk);
    chk("ldrdy_after_rst", ldrdy, 1);
  endtask

  task automatic end_run(input bit corrupt);
    send_word(32'hFFFF_FFFF);
`ifdef LOTR_LOADER_CHECKSUM_EN
    if (corrupt) begin
      exp_err = 1;
      send_word(exp_csum ^ 32'h1);
    end else send_word(exp_csum);
`else
    if (corrupt) exp_err = 1;
`endif
    chk("end_core_rst", core_rst, exp_err);
    chk("end_done", done, !exp_err);
    chk("end_err", err, exp_err);
    chk("end_pending_writes", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("done_ldrdy_low", ldrdy, 0);
    chk("done_terminal", done, !exp_err);
  endtask

  task automatic rand_frame();
    logic [31:0] hdr, lw;
    logic [31:0] d[$];
    int          len, t, k;
    logic        s;
    logic [23:0] a;
    s = 1'($urandom_range(0, 1));
    k = $urandom_range(0, 9);
    t = (k < 4) ? 0 : (k < 7) ? 1 : (k < 9) ? 127 : 3;
    len = $urandom_range(0, 4);
    a = 24'((s ? 'h1000 : 0) + 4 * $urandom_range(0, 1023));
    k = $urandom_range(0, 9);
    if (k == 0) a[0] = 1'b1;
    else if (k == 1) a = 24'((s ? 'h1000 : 0) + 'hFFC);
    else if (k == 2) a = 24'($urandom_range(0, 'h3FFF) & ~3);
    hdr = {s, 7'(t), a};
    lw  = {16'($urandom), 16'(len)};
    for (int i = 0; i < len; i++) d.push_back($urandom);
    send_frame(hdr, lw, d, 1);
  endtask

  initial begin
    logic [31:0] d[$];

    // Directed: two good frames, stalled write, clean END
    do_reset();
    rdy_mode = 2;
    d.delete(); d.push_back(32'h0000_0013); d.push_back(32'h0010_0093);
    send_frame(32'h0000_0000, 32'h0000_0002, d, 1);
    chk("wr_latency", en, 1);
    @(negedge clk);
    chk("wr_done_en", en, 0);
    chk("ldrdy_after_wr", ldrdy, 1);
    rdy_mode = 1;
    d.delete(); d.push_back(32'hDEAD_BEEF);
    send_frame(32'hFF00_1000, 32'h0000_0001, d, 1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_en", en, 1);
      chk("stall_ldrdy", ldrdy, 0);
      @(negedge clk);
    end
    rdy_mode = 2;
    end_run(0);
    chk("log_size", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      chk("lit0", log_q[0], {2'b01, 1'b0, 24'h000000, 32'h0000_0013});
      chk("lit1", log_q[1], {2'b01, 1'b0, 24'h000004, 32'h0010_0093});
      chk("lit2", log_q[2], {2'b11, 1'b1, 24'h001000, 32'hDEAD_BEEF});
    end

    // Out-of-range frame is discarded, following frame still loads, cores held
    do_reset();
    gaps = 1;
    d.delete(); d.push_back($urandom); d.push_back($urandom);
    send_frame(32'h0000_0FFC, 32'h0000_0002, d, 1);
    chk("bad_frame_err", err, 1);
    chk("bad_frame_model", exp_err, 1);
    d.delete(); d.push_back($urandom); d.push_back($urandom); d.push_back($urandom);
    send_frame(32'h0100_0010, 32'hABCD_0003, d, 1);
    chk("core_rst_held", core_rst, 1);
    end_run(0);

    // Reset mid-frame and mid-write, then a fresh load
    do_reset();
    send_word(32'h0000_0020);
    send_word(32'h0000_0001);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset();
    rdy_mode = 1;
    d.delete(); d.push_back(32'h5555_AAAA);
    send_frame(32'h0100_0040, 32'h0000_0001, d, 0);
    chk("pending_wr_before_rst", en, 1);
    do_reset();
    d.delete(); d.push_back($urandom); d.push_back($urandom);
    send_frame(32'h0000_0008, 32'h0000_0002, d, 1);
    end_run(0);

    // Randomized images
    for (int r = 0; r < 8; r++) begin
      do_reset();
      gaps = (r % 2 == 0);
      for (int f = 0; f < int'($urandom_range(2, 5)); f++) rand_frame();
      end_run(0);
    end

`ifdef LOTR_LOADER_CHECKSUM_EN
    do_reset();
    d.delete(); d.push_back(32'h1); d.push_back(32'h3);
    send_frame(32'h0000_0000, 32'h0000_0002, d, 1);
    chk("cksum_model", exp_csum, 32'h2);
    end_run(0);
    do_reset();
    d.delete(); d.push_back(32'h1); d.push_back(32'h3);
    send_frame(32'h0000_0000, 32'h0000_0002, d, 1);
    end_run(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
